// File: rtl/pwm_multichannel.sv
// Multi-channel PWM: one shared prescaler and period counter, edge- or center-aligned,
// double-buffered duty/period/mode, per-channel inversion.
module pwm_multichannel #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 10,
  parameter int PREDIV   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [$clog2(CHANNELS+2)-1:0] wr_addr,
  input  logic [CNT_W-1:0]              wr_data,
  output logic [CHANNELS-1:0]           out,
  output logic                          period_start
);

  localparam int AW    = $clog2(CHANNELS+2);
  localparam int PRE_W = (PREDIV > 1) ? $clog2(PREDIV) : 1;

  logic [CNT_W-1:0]    top_s_q, top_a_q, cnt_q, cnt_d, cnt_step;
  logic                center_s_q, center_a_q, enable_q;
  logic                dir_q, dir_d, dir_step;
  logic                bnd, tick, load_a;
  logic [CHANNELS-1:0] inv_q, act, out_q, out_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic                ps_q, ps_d;
  logic                wr_top, wr_ctrl;

  assign wr_top  = wr_en && (wr_addr == AW'(CHANNELS));
  assign wr_ctrl = wr_en && (wr_addr == AW'(CHANNELS + 1));
  assign tick    = enable_q && (pre_q == PRE_W'(PREDIV - 1));
  // Active registers follow the shadows at a boundary, or continuously while disabled.
  assign load_a  = !enable_q || (tick && bnd);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [CNT_W-1:0] duty_s_q, duty_a_q;
    logic             wr_duty;

    assign wr_duty = wr_en && (wr_addr == AW'(gi));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        duty_s_q <= '0;
        duty_a_q <= '0;
      end else begin
        if (load_a)  duty_a_q <= duty_s_q;
        if (wr_duty) duty_s_q <= wr_data;
      end
    end

    assign act[gi] = (cnt_q < duty_a_q);
  end

  // Counter value and direction that a tick would produce; bnd marks the period boundary.
  always_comb begin
    cnt_step = cnt_q + CNT_W'(1);
    dir_step = dir_q;
    bnd      = 1'b0;
    if (!center_a_q) begin
      dir_step = 1'b0;
      if (cnt_q >= top_a_q) begin
        cnt_step = '0;
        bnd      = 1'b1;
      end
    end else if (top_a_q == '0) begin
      cnt_step = '0;
      dir_step = 1'b0;
      bnd      = 1'b1;
    end else if (dir_q || (cnt_q >= top_a_q)) begin
      cnt_step = cnt_q - CNT_W'(1);
      dir_step = 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        dir_step = 1'b0;
        bnd      = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    pre_d = pre_q + PRE_W'(1);
    ps_d  = 1'b0;
    out_d = inv_q;
    if (!enable_q) begin
      cnt_d = '0;
      dir_d = 1'b0;
      pre_d = '0;
    end else begin
      out_d = act ^ inv_q;
      ps_d  = tick && bnd;
      if (tick) begin
        pre_d = '0;
        cnt_d = cnt_step;
        dir_d = dir_step;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_s_q    <= '1;
      top_a_q    <= '1;
      center_s_q <= 1'b0;
      center_a_q <= 1'b0;
      enable_q   <= 1'b0;
      inv_q      <= '0;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      pre_q      <= '0;
      out_q      <= '0;
      ps_q       <= 1'b0;
    end else begin
      if (load_a) begin
        top_a_q    <= top_s_q;
        center_a_q <= center_s_q;
      end
      if (wr_top) top_s_q <= wr_data;
      if (wr_ctrl) begin
        enable_q   <= wr_data[0];
        center_s_q <= wr_data[1];
        inv_q      <= wr_data[2 +: CHANNELS];
      end
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      pre_q <= pre_d;
      out_q <= out_d;
      ps_q  <= ps_d;
    end
  end

  assign out          = out_q;
  assign period_start = ps_q;

endmodule
